reorder_buffer: RTL and testbench

//  In-order completion buffer paired with ALU_reservation_station. Allocates one tag per

---
 rtl/reorder_buffer_pkg.sv | 17 +
 rtl/reorder_buffer_alurs_tag_table.sv | 56 +++++
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 tb/tb_reorder_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizing for the reorder buffer and its ALU RS tag table.
// Optional flush support is enabled by defining ROB_FLUSH_EN.
package reorder_buffer_pkg;

   localparam int ROB_SIZE          = 16;
   localparam int ROB_INDEX_BITS    = 4;
   localparam int ALU_RS_SIZE       = 8;
   localparam int ALU_RS_INDEX_BITS = 3;

   typedef struct packed {
      logic        valid;
      logic        done;
      logic [4:0]  rd;
      logic [31:0] data;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_alurs_tag_table.sv
// Remembers which ROB tag each ALU RS slot is computing; turns RS completions into ROB writes.
// With ROB_FLUSH_EN defined, a flush input invalidates every slot.
module rob_alurs_tag_table
   import reorder_buffer_pkg::*;
#(
   parameter int alu_rs_size       = ALU_RS_SIZE,
   parameter int alu_rs_index_bits = ALU_RS_INDEX_BITS,
   parameter int rob_index_bits    = ROB_INDEX_BITS
) (
   input  logic                                          clk,
   input  logic                                          rst,
`ifdef ROB_FLUSH_EN
   input  logic                                          flush,
`endif
   input  logic                                          install,
   input  logic [alu_rs_index_bits-1:0]                  widx,
   input  logic [rob_index_bits-1:0]                     tag_in,
   input  logic [alu_rs_size-1:0]                        done_alurs,
   output logic [alu_rs_size-1:0]                        wb_en,
   output logic [alu_rs_size-1:0][rob_index_bits-1:0]    wb_tag
);

   genvar gi;
   generate
      for (gi = 0; gi < alu_rs_size; gi++) begin : g_slot
         logic [rob_index_bits-1:0] tag_reg;
         logic                      tag_v_reg;
         logic                      load;

         assign load       = install && (widx == alu_rs_index_bits'(gi));
         assign wb_en[gi]  = done_alurs[gi] & tag_v_reg;
         assign wb_tag[gi] = tag_reg;

         // A reload in the same cycle as a writeback wins: the old tag is used for
         // this cycle's write, the new tag stays armed.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               tag_reg   <= '0;
               tag_v_reg <= 1'b0;
            end
`ifdef ROB_FLUSH_EN
            else if (flush) begin
               tag_v_reg <= 1'b0;
            end
`endif
            else if (load) begin
               tag_reg   <= tag_in;
               tag_v_reg <= 1'b1;
            end else if (wb_en[gi]) begin
               tag_v_reg <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates tags, captures ALU RS results, broadcasts and commits.
// Defining ROB_FLUSH_EN adds a flush input that empties the buffer (results kept).
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int rob_size          = ROB_SIZE,
   parameter int rob_index_bits    = ROB_INDEX_BITS,
   parameter int alu_rs_size       = ALU_RS_SIZE,
   parameter int alu_rs_index_bits = ALU_RS_INDEX_BITS
) (
   input  logic                                  clk,
   input  logic                                  rst,
`ifdef ROB_FLUSH_EN
   input  logic                                  flush,
`endif
   input  logic                                  alloc_dec,
   input  logic [4:0]                            rd_dec,
   input  logic                                  to_alurs_dec,
   input  logic [alu_rs_index_bits-1:0]          widx_alurs,
   input  logic [alu_rs_size-1:0]                done_alurs,
   input  logic [alu_rs_size-1:0][31:0]          data_alurs,
   output logic [rob_index_bits-1:0]             tail_rob,
   output logic                                  rob_full,
   output logic                                  rob_empty,
   output logic [rob_size-1:0]                   done_rob,
   output logic [rob_size-1:0][31:0]             data_rob,
   output logic                                  commit_valid,
   output logic [4:0]                            commit_rd,
   output logic [31:0]                           commit_data,
   output logic [rob_index_bits-1:0]             commit_idx
);

   logic [rob_index_bits-1:0]                  head_reg, head_next;
   logic [rob_index_bits-1:0]                  tail_reg, tail_next;
   logic [rob_index_bits:0]                    count_reg, count_next;
   logic                                       alloc_ok;
   logic [alu_rs_size-1:0]                     wb_en;
   logic [alu_rs_size-1:0][rob_index_bits-1:0] wb_tag;
   rob_entry_t                                 entry_q [rob_size];
   rob_entry_t                                 head_entry;

   rob_alurs_tag_table #(
      .alu_rs_size       (alu_rs_size),
      .alu_rs_index_bits (alu_rs_index_bits),
      .rob_index_bits    (rob_index_bits)
   ) u_tag_table (
      .clk        (clk),
      .rst        (rst),
`ifdef ROB_FLUSH_EN
      .flush      (flush),
`endif
      .install    (alloc_ok && to_alurs_dec),
      .widx       (widx_alurs),
      .tag_in     (tail_reg),
      .done_alurs (done_alurs),
      .wb_en      (wb_en),
      .wb_tag     (wb_tag)
   );

   assign head_entry = entry_q[head_reg];

`ifdef ROB_FLUSH_EN
   assign alloc_ok     = alloc_dec & ~rob_full & ~flush;
   assign commit_valid = head_entry.valid & head_entry.done & ~flush;
`else
   assign alloc_ok     = alloc_dec & ~rob_full;
   assign commit_valid = head_entry.valid & head_entry.done;
`endif

   assign commit_rd   = head_entry.rd;
   assign commit_data = head_entry.data;
   assign commit_idx  = head_reg;
   assign tail_rob    = tail_reg;
   assign rob_full    = (count_reg == (rob_index_bits + 1)'(rob_size));
   assign rob_empty   = (count_reg == '0);

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (alloc_ok)     tail_next = tail_reg + 1'b1;
      if (commit_valid) head_next = head_reg + 1'b1;
      case ({alloc_ok, commit_valid})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end
`ifdef ROB_FLUSH_EN
      else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end
`endif
      else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < rob_size; gi++) begin : g_entry
         rob_entry_t  entry_reg;
         logic        wb_hit;
         logic [31:0] wb_data;

         // Live slots always target distinct tags, so at most one slot hits per entry.
         always_comb begin
            wb_hit  = 1'b0;
            wb_data = '0;
            for (int j = 0; j < alu_rs_size; j++) begin
               if (wb_en[j] && (wb_tag[j] == rob_index_bits'(gi))) begin
                  wb_hit  = 1'b1;
                  wb_data = data_alurs[j];
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               entry_reg <= '0;
            end
`ifdef ROB_FLUSH_EN
            else if (flush) begin
               entry_reg.valid <= 1'b0;
               entry_reg.done  <= 1'b0;
            end
`endif
            else if (alloc_ok && (tail_reg == rob_index_bits'(gi))) begin
               entry_reg <= '{1'b1, 1'b0, rd_dec, 32'd0};
            end else begin
               if (wb_hit) begin
                  entry_reg.done <= 1'b1;
                  entry_reg.data <= wb_data;
               end
               if (commit_valid && (head_reg == rob_index_bits'(gi))) begin
                  entry_reg.valid <= 1'b0;
               end
            end
         end

         assign entry_q[gi]  = entry_reg;
         assign done_rob[gi] = entry_reg.valid & entry_reg.done;
         assign data_rob[gi] = entry_reg.data;
      end
   endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer; flush sequence runs when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
`ifdef ROB_FLUSH_EN
   logic              flush = 1'b0;
`endif
   logic              alloc_dec;
   logic [4:0]        rd_dec;
   logic              to_alurs_dec;
   logic [2:0]        widx_alurs;
   logic [7:0]        done_alurs;
   logic [7:0][31:0]  data_alurs;
   logic [3:0]        tail_rob;
   logic              rob_full;
   logic              rob_empty;
   logic [15:0]       done_rob;
   logic [15:0][31:0] data_rob;
   logic              commit_valid;
   logic [4:0]        commit_rd;
   logic [31:0]       commit_data;
   logic [3:0]        commit_idx;

   int tests = 0;
   int fails = 0;

   reorder_buffer dut (
      .clk          (clk),
      .rst          (rst),
`ifdef ROB_FLUSH_EN
      .flush        (flush),
`endif
      .alloc_dec    (alloc_dec),
      .rd_dec       (rd_dec),
      .to_alurs_dec (to_alurs_dec),
      .widx_alurs   (widx_alurs),
      .done_alurs   (done_alurs),
      .data_alurs   (data_alurs),
      .tail_rob     (tail_rob),
      .rob_full     (rob_full),
      .rob_empty    (rob_empty),
      .done_rob     (done_rob),
      .data_rob     (data_rob),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_data  (commit_data),
      .commit_idx   (commit_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        alloc;
      logic [4:0]  rd;
      logic        to_rs;
      logic [2:0]  widx;
      logic [7:0]  done;
      logic [31:0] base;
      logic [3:0]  e_tail;
      logic        e_full;
      logic        e_empty;
      logic        e_cv;
      logic [4:0]  e_crd;
      logic [31:0] e_cdata;
      logic [3:0]  e_cidx;
      logic [15:0] e_done_rob;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic a, input logic [4:0] rd, input logic t,
                               input logic [2:0] w, input logic [7:0] d, input logic [31:0] base,
                               input logic [3:0] et, input logic ef, input logic ee, input logic ecv,
                               input logic [4:0] ecrd, input logic [31:0] ecd, input logic [3:0] eci,
                               input logic [15:0] edr);
      vec_t v;
      v.alloc = a; v.rd = rd; v.to_rs = t; v.widx = w; v.done = d; v.base = base;
      v.e_tail = et; v.e_full = ef; v.e_empty = ee; v.e_cv = ecv;
      v.e_crd = ecrd; v.e_cdata = ecd; v.e_cidx = eci; v.e_done_rob = edr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Slot j carries base + j*0x10000 so simultaneous writebacks are distinguishable.
   task automatic drive(input logic a, input logic [4:0] rd, input logic t, input logic [2:0] w,
                        input logic [7:0] d, input logic [31:0] base);
      alloc_dec    = a;
      rd_dec       = rd;
      to_alurs_dec = t;
      widx_alurs   = w;
      done_alurs   = d;
      for (int j = 0; j < 8; j++) data_alurs[j] = base + (32'(j) << 16);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      drive(0, 0, 0, 0, 8'h00, 32'h0);
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 8'h00, 32'h0);

      //          alloc rd to widx done   base           tail full empty cv crd cdata         cidx done_rob
      vecs[0]  = mk(1, 5, 1, 2, 8'h00, 32'h0,          4'd1, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[1]  = mk(0, 0, 0, 0, 8'h04, 32'h0000DEAD,   4'd1, 0, 0, 1, 5'd5, 32'h0002DEAD, 4'd0, 16'h0001);
      vecs[2]  = mk(0, 0, 0, 0, 8'h00, 32'h0,          4'd1, 0, 1, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[3]  = mk(1, 7, 1, 0, 8'h00, 32'h0,          4'd2, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[4]  = mk(1, 9, 1, 1, 8'h00, 32'h0,          4'd3, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[5]  = mk(0, 0, 0, 0, 8'h02, 32'h11110000,   4'd3, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0004);
      vecs[6]  = mk(0, 0, 0, 0, 8'h00, 32'h0,          4'd3, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0004);
      vecs[7]  = mk(0, 0, 0, 0, 8'h01, 32'h22220000,   4'd3, 0, 0, 1, 5'd7, 32'h22220000, 4'd1, 16'h0006);
      vecs[8]  = mk(0, 0, 0, 0, 8'h00, 32'h0,          4'd3, 0, 0, 1, 5'd9, 32'h11120000, 4'd2, 16'h0004);
      vecs[9]  = mk(0, 0, 0, 0, 8'h00, 32'h0,          4'd3, 0, 1, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[10] = mk(1, 1, 1, 4, 8'h00, 32'h0,          4'd4, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[11] = mk(1, 2, 1, 5, 8'h00, 32'h0,          4'd5, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[12] = mk(1, 3, 0, 0, 8'h30, 32'h30000000,   4'd6, 0, 0, 1, 5'd1, 32'h30040000, 4'd3, 16'h0018);
      vecs[13] = mk(1, 4, 0, 0, 8'h00, 32'h0,          4'd7, 0, 0, 1, 5'd2, 32'h30050000, 4'd4, 16'h0010);
      vecs[14] = mk(0, 0, 0, 0, 8'h30, 32'h40000000,   4'd7, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);
      vecs[15] = mk(1, 6, 0, 0, 8'h00, 32'h0,          4'd8, 0, 0, 0, 5'd0, 32'h0,        4'd0, 16'h0000);

      // Reset state while rst is held low.
      #12;
      check("reset_empty", 32'(rob_empty), 32'd1);
      check("reset_full", 32'(rob_full), 32'd0);
      check("reset_tail", 32'(tail_rob), 32'd0);
      check("reset_done_rob", 32'(done_rob), 32'd0);
      check("reset_commit_valid", 32'(commit_valid), 32'd0);
      $display("[TB] reset: empty=%0d full=%0d tail=%0d", rob_empty, rob_full, tail_rob);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].alloc, vecs[i].rd, vecs[i].to_rs, vecs[i].widx, vecs[i].done, vecs[i].base);
         tick();
         check($sformatf("v%0d_tail", i), 32'(tail_rob), 32'(vecs[i].e_tail));
         check($sformatf("v%0d_full", i), 32'(rob_full), 32'(vecs[i].e_full));
         check($sformatf("v%0d_empty", i), 32'(rob_empty), 32'(vecs[i].e_empty));
         check($sformatf("v%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
         check($sformatf("v%0d_done_rob", i), 32'(done_rob), 32'(vecs[i].e_done_rob));
         if (vecs[i].e_cv) begin
            check($sformatf("v%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].e_crd));
            check($sformatf("v%0d_commit_data", i), commit_data, vecs[i].e_cdata);
            check($sformatf("v%0d_commit_idx", i), 32'(commit_idx), 32'(vecs[i].e_cidx));
         end
         $display("[TB] vec %0d: tail=%0d full=%0d empty=%0d cv=%0d rd=%0d data=%h idx=%0d done_rob=%h",
                  i, tail_rob, rob_full, rob_empty, commit_valid, commit_rd, commit_data,
                  commit_idx, done_rob);
      end

      // Asynchronous reset with three live entries, between clock edges.
      drive(0, 0, 0, 0, 8'h00, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      check("async_rst_empty", 32'(rob_empty), 32'd1);
      check("async_rst_done_rob", 32'(done_rob), 32'd0);
      check("async_rst_tail", 32'(tail_rob), 32'd0);
      check("async_rst_cv", 32'(commit_valid), 32'd0);
      $display("[TB] async reset: empty=%0d tail=%0d done_rob=%h", rob_empty, tail_rob, done_rob);
      rst = 1'b1;

      // Fill to 16 entries; overflow alloc ignored; full still blocks alloc during commit.
      drive(1, 10, 1, 0, 8'h00, 32'h0);
      tick();
      for (int i = 1; i < 15; i++) begin
         drive(1, 5'(i), 0, 0, 8'h00, 32'h0);
         tick();
      end
      check("fill15_full", 32'(rob_full), 32'd0);
      check("fill15_tail", 32'(tail_rob), 32'd15);
      drive(1, 15, 0, 0, 8'h00, 32'h0);
      tick();
      check("fill16_full", 32'(rob_full), 32'd1);
      check("fill16_tail", 32'(tail_rob), 32'd0);
      check("fill16_empty", 32'(rob_empty), 32'd0);
      $display("[TB] fill16: full=%0d tail=%0d", rob_full, tail_rob);
      drive(1, 31, 0, 0, 8'h00, 32'h0);
      tick();
      check("alloc17_tail", 32'(tail_rob), 32'd0);
      check("alloc17_full", 32'(rob_full), 32'd1);
      $display("[TB] alloc17: full=%0d tail=%0d", rob_full, tail_rob);
      drive(1, 31, 0, 0, 8'h01, 32'h00ABC000);
      tick();
      check("full_wb_cv", 32'(commit_valid), 32'd1);
      check("full_wb_rd", 32'(commit_rd), 32'd10);
      check("full_wb_data", commit_data, 32'h00ABC000);
      check("full_wb_idx", 32'(commit_idx), 32'd0);
      check("full_wb_tail", 32'(tail_rob), 32'd0);
      $display("[TB] full writeback: cv=%0d rd=%0d data=%h", commit_valid, commit_rd, commit_data);
      drive(1, 12, 0, 0, 8'h00, 32'h0);
      tick();
      check("full_commit_full", 32'(rob_full), 32'd0);
      check("full_commit_tail", 32'(tail_rob), 32'd0);
      check("full_commit_cv", 32'(commit_valid), 32'd0);
      $display("[TB] commit while full: full=%0d tail=%0d", rob_full, tail_rob);
      drive(1, 12, 0, 0, 8'h00, 32'h0);
      tick();
      check("refill_tail", 32'(tail_rob), 32'd1);
      check("refill_full", 32'(rob_full), 32'd1);
      $display("[TB] refill: full=%0d tail=%0d", rob_full, tail_rob);

      // Slot 3 writes back old tag 4 while being reloaded with tag 7.
      pulse_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1, 5'(i), (i == 4), 3'd3, 8'h00, 32'h0);
         tick();
      end
      drive(1, 21, 1, 3, 8'h08, 32'hA0000000);
      tick();
      check("reload_done_rob", 32'(done_rob), 32'h0010);
      check("reload_data4", data_rob[4], 32'hA0030000);
      check("reload_tail", 32'(tail_rob), 32'd8);
      $display("[TB] reload: done_rob=%h data4=%h", done_rob, data_rob[4]);
      drive(0, 0, 0, 0, 8'h08, 32'hB0000000);
      tick();
      check("newtag_done_rob", 32'(done_rob), 32'h0090);
      check("newtag_data7", data_rob[7], 32'hB0030000);
      check("newtag_data4", data_rob[4], 32'hA0030000);
      $display("[TB] new tag wb: done_rob=%h data7=%h", done_rob, data_rob[7]);
      drive(0, 0, 0, 0, 8'h08, 32'hC0000000);
      tick();
      check("held_data4", data_rob[4], 32'hA0030000);
      check("held_data7", data_rob[7], 32'hB0030000);
      check("held_cv", 32'(commit_valid), 32'd0);
      $display("[TB] held done: data4=%h data7=%h", data_rob[4], data_rob[7]);

`ifdef ROB_FLUSH_EN
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 5'(i + 1), (i == 0), 3'd0, 8'h00, 32'h0);
         tick();
      end
      drive(0, 0, 0, 0, 8'h01, 32'h55550000);
      tick();
      check("preflush_cv", 32'(commit_valid), 32'd1);
      drive(1, 2, 0, 0, 8'h00, 32'h0);
      flush = 1'b1;
      #1;
      check("flush_cv", 32'(commit_valid), 32'd0);
      tick();
      flush = 1'b0;
      check("flush_empty", 32'(rob_empty), 32'd1);
      check("flush_tail", 32'(tail_rob), 32'd0);
      check("flush_done_rob", 32'(done_rob), 32'd0);
      $display("[TB] flush: empty=%0d tail=%0d done_rob=%h", rob_empty, tail_rob, done_rob);
      drive(1, 3, 0, 0, 8'h00, 32'h0);
      tick();
      drive(0, 0, 0, 0, 8'h01, 32'h66660000);
      tick();
      check("flush_tagv_cleared", 32'(done_rob), 32'd0);
      $display("[TB] post-flush stale slot: done_rob=%h", done_rob);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
